seq_match_monitor: RTL

Downstream consumer of the serial `1011` detector's single-cycle match pulse. It counts matches, measures the cycle distance between consecutive matches, and flags bursts of closely spaced matches. It hands software-visible snapshots out over a valid/ready port. It sits between the detector's `z` output and the status/interrupt fabric.

---
 rtl/seq_mon_pkg.sv | 25 ++
 rtl/sat_counter.sv | 66 ++++++
 rtl/seq_match_monitor.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mon_pkg.sv
// -----------------------------------------------------------------------------
// seq_mon_pkg
// Shared types and default widths for the sequence match monitor.
//   gap_state_t : gap FSM states (WAIT_FIRST, TIMING)
//   rep_state_t : report port states (EMPTY, FULL)
//   *_DEF       : default parameter values used by the monitor and sub-modules
// -----------------------------------------------------------------------------
package seq_mon_pkg;

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        TIMING     = 1'b1
    } gap_state_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rep_state_t;

    localparam int CNT_W_DEF     = 8;
    localparam int GAP_W_DEF     = 8;
    localparam int BURST_GAP_DEF = 4;
    localparam int BURST_N_DEF   = 3;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear and load.
// Priority: clr > load > inc. The counter holds at all-ones.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear to zero
//   inc       : increment request (ignored at all-ones)
//   load      : load load_val
//   load_val  : value for load
//   cnt       : registered count
//   cnt_nxt   : value cnt takes at the next edge (for post-update snapshots)
//   sat       : registered flag, high while cnt is all-ones
// -----------------------------------------------------------------------------
module sat_counter
    import seq_mon_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;
    logic         r_sat;

    // Next-count selection with saturation at all-ones
    always_comb begin
        w_nxt = r_cnt;
        if (clr) begin
            w_nxt = {W{1'b0}};
        end else if (load) begin
            w_nxt = load_val;
        end else if (inc && (r_cnt != MAX_VAL)) begin
            w_nxt = r_cnt + ONE_VAL;
        end else begin
            w_nxt = r_cnt;
        end
    end

    // Count and saturation flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {W{1'b0}};
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_nxt;
            r_sat <= (w_nxt == MAX_VAL);
        end
    end

    assign cnt     = r_cnt;
    assign cnt_nxt = w_nxt;
    assign sat     = r_sat;

endmodule

// File: rtl/seq_match_monitor.sv
// -----------------------------------------------------------------------------
// seq_match_monitor
// Consumes the 1011 detector match pulse: counts matches, measures the cycle
// distance between consecutive matches, optionally flags bursts of closely
// spaced matches, and offers snapshots over a valid/ready report port.
// Optional feature macro: SEQ_MON_BURST_EN (burst run counter + burst_irq).
//   clk, rst        : clock, asynchronous active-high reset
//   en, z_in, clear : enable, match pulse, synchronous clear
//   snap            : snapshot request
//   match_cnt, sat  : live saturating match count and its sticky flag
//   last_gap        : cycles between the last two accepted matches
//   burst_irq       : one-cycle burst pulse (0 when feature not built)
//   rep_valid/ready : report handshake
//   rep_cnt/gap/sat : snapshot contents; rep_ovf sticky dropped-snap flag
// -----------------------------------------------------------------------------
module seq_match_monitor
    import seq_mon_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GAP_W     = GAP_W_DEF,
    parameter int BURST_GAP = BURST_GAP_DEF,
    parameter int BURST_N   = BURST_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             z_in,
    input  logic             clear,
    input  logic             snap,
    output logic [CNT_W-1:0] match_cnt,
    output logic             sat,
    output logic [GAP_W-1:0] last_gap,
    output logic             burst_irq,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic [CNT_W-1:0] rep_cnt,
    output logic [GAP_W-1:0] rep_gap,
    output logic             rep_sat,
    output logic             rep_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    logic             w_acc;
    logic [CNT_W-1:0] w_match_cnt;
    logic [CNT_W-1:0] w_match_nxt;
    logic             w_match_sat;
    logic [GAP_W-1:0] w_gap_cnt;
    logic [GAP_W-1:0] w_unused_gap_nxt;
    logic             w_unused_gap_sat;

    gap_state_t       r_gap_state;
    gap_state_t       w_gap_state_nxt;
    logic             w_gap_load;
    logic             w_gap_inc;
    logic             w_gap_capture;

    logic [GAP_W-1:0] r_last_gap;
    logic [GAP_W-1:0] w_last_gap_nxt;

    rep_state_t       r_rep_state;
    rep_state_t       w_rep_state_nxt;
    logic             w_xfer;
    logic             w_rep_load;
    logic             w_rep_drop;
    logic             r_rep_valid;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [GAP_W-1:0] r_rep_gap;
    logic             r_rep_sat;
    logic             r_rep_ovf;

    // A clear in the same cycle as a match drops the match.
    assign w_acc = z_in & en & ~clear;

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .inc      (w_acc),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .cnt      (w_match_cnt),
        .cnt_nxt  (w_match_nxt),
        .sat      (w_match_sat)
    );

    sat_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .inc      (w_gap_inc),
        .load     (w_gap_load),
        .load_val (GAP_ONE),
        .cnt      (w_gap_cnt),
        .cnt_nxt  (w_unused_gap_nxt),
        .sat      (w_unused_gap_sat)
    );

    // Gap FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_state <= WAIT_FIRST;
        end else begin
            r_gap_state <= w_gap_state_nxt;
        end
    end

    // Gap FSM next state; en low freezes, clear restarts timing
    always_comb begin
        w_gap_state_nxt = r_gap_state;
        if (clear) begin
            w_gap_state_nxt = WAIT_FIRST;
        end else if (!en) begin
            w_gap_state_nxt = r_gap_state;
        end else begin
            case (r_gap_state)
                WAIT_FIRST: w_gap_state_nxt = w_acc ? TIMING : WAIT_FIRST;
                TIMING:     w_gap_state_nxt = TIMING;
                default:    w_gap_state_nxt = WAIT_FIRST;
            endcase
        end
    end

    // Gap FSM controls: every accepted match restarts the gap at 1,
    // only matches seen while timing produce a measured gap.
    always_comb begin
        w_gap_load    = w_acc;
        w_gap_capture = 1'b0;
        w_gap_inc     = 1'b0;
        if (r_gap_state == TIMING) begin
            w_gap_capture = w_acc;
            w_gap_inc     = en & ~clear & ~w_acc;
        end else begin
            w_gap_capture = 1'b0;
            w_gap_inc     = 1'b0;
        end
    end

    // Next last_gap value, also used as the post-update snapshot source
    always_comb begin
        w_last_gap_nxt = r_last_gap;
        if (clear) begin
            w_last_gap_nxt = {GAP_W{1'b0}};
        end else if (w_gap_capture) begin
            w_last_gap_nxt = w_gap_cnt;
        end else begin
            w_last_gap_nxt = r_last_gap;
        end
    end

    // last_gap register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gap <= {GAP_W{1'b0}};
        end else begin
            r_last_gap <= w_last_gap_nxt;
        end
    end

`ifdef SEQ_MON_BURST_EN
    localparam int RUN_W = $clog2(BURST_N + 1) + 1;
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    logic [RUN_W-1:0] r_run_cnt;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_burst_nxt;
    logic             r_burst_irq;
    logic             w_close;

    assign w_close = w_gap_capture & (w_gap_cnt <= GAP_W'(BURST_GAP));

    // Run of close gaps; reaching BURST_N fires one pulse and restarts the run
    always_comb begin
        w_run_nxt   = r_run_cnt;
        w_burst_nxt = 1'b0;
        if (clear) begin
            w_run_nxt = {RUN_W{1'b0}};
        end else if (w_close) begin
            if ((r_run_cnt + RUN_ONE) == RUN_W'(BURST_N)) begin
                w_run_nxt   = {RUN_W{1'b0}};
                w_burst_nxt = 1'b1;
            end else begin
                w_run_nxt = r_run_cnt + RUN_ONE;
            end
        end else if (w_gap_capture) begin
            w_run_nxt = {RUN_W{1'b0}};
        end else begin
            w_run_nxt = r_run_cnt;
        end
    end

    // Run counter and burst pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt   <= {RUN_W{1'b0}};
            r_burst_irq <= 1'b0;
        end else begin
            r_run_cnt   <= w_run_nxt;
            r_burst_irq <= w_burst_nxt;
        end
    end

    assign burst_irq = r_burst_irq;
`else
    // Burst thresholds have no effect without the burst feature.
    logic w_unused_burst_cfg;
    assign w_unused_burst_cfg = (BURST_GAP == 0) ^ (BURST_N == 0);
    assign burst_irq = 1'b0;
`endif

    // Report FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_state <= EMPTY;
        end else begin
            r_rep_state <= w_rep_state_nxt;
        end
    end

    assign w_xfer = (r_rep_state == FULL) & rep_ready;

    // Report FSM next state; a snap during a transfer keeps the port full
    always_comb begin
        w_rep_state_nxt = r_rep_state;
        case (r_rep_state)
            EMPTY:   w_rep_state_nxt = snap ? FULL : EMPTY;
            FULL:    w_rep_state_nxt = (w_xfer && !snap) ? EMPTY : FULL;
            default: w_rep_state_nxt = EMPTY;
        endcase
    end

    // Report FSM controls: load when a slot is free, drop otherwise
    always_comb begin
        w_rep_load = 1'b0;
        w_rep_drop = 1'b0;
        if (snap) begin
            w_rep_load = (r_rep_state == EMPTY) | w_xfer;
            w_rep_drop = (r_rep_state == FULL) & ~rep_ready;
        end else begin
            w_rep_load = 1'b0;
            w_rep_drop = 1'b0;
        end
    end

    // Report registers; snapshots take post-update values so a
    // same-cycle match is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_valid <= 1'b0;
            r_rep_cnt   <= {CNT_W{1'b0}};
            r_rep_gap   <= {GAP_W{1'b0}};
            r_rep_sat   <= 1'b0;
            r_rep_ovf   <= 1'b0;
        end else begin
            r_rep_valid <= (w_rep_state_nxt == FULL);
            if (w_rep_load) begin
                r_rep_cnt <= w_match_nxt;
                r_rep_gap <= w_last_gap_nxt;
                r_rep_sat <= (w_match_nxt == CNT_MAX);
            end
            if (clear) begin
                r_rep_ovf <= 1'b0;
            end else if (w_rep_drop) begin
                r_rep_ovf <= 1'b1;
            end
        end
    end

    assign match_cnt = w_match_cnt;
    assign sat       = w_match_sat;
    assign last_gap  = r_last_gap;
    assign rep_valid = r_rep_valid;
    assign rep_cnt   = r_rep_cnt;
    assign rep_gap   = r_rep_gap;
    assign rep_sat   = r_rep_sat;
    assign rep_ovf   = r_rep_ovf;

endmodule
